uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte width per beat.
REQ-003 Parameter IDLE_TIMEOUT, default 1024, SHALL set the number of idle owner cycles before a forced release (>=2).
REQ-004 clk  in  1  system clock; all logic on posedge clk.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester beat valid.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_last  in  NUM_REQ  marks the final beat of requester i's message.
REQ-009 req_ready  out  NUM_REQ  beat accepted from requester i when req_valid[i] and req_ready[i] are both high.
REQ-010 tx_valid  out  1  byte valid toward the shared UART transmitter.
REQ-011 tx_data  out  DATA_WIDTH  byte toward the transmitter.
REQ-012 tx_ready  in  1  transmitter ready; transfer occurs when tx_valid and tx_ready are both high.
REQ-013 grant_id  out  $clog2(NUM_REQ)  index of the current owner; 0 when no owner.
REQ-014 busy  out  1  high while a requester owns the transmitter.
REQ-015 timeout_pulse  out  1  one-cycle pulse on a forced release.

Function
REQ-016 The FSM SHALL have two states: ARB (no owner) and OWN (one owner holds the transmitter).
REQ-017 In ARB with any req_valid high, the block SHALL select the first valid requester in round-robin order starting at last_grant+1 (mod NUM_REQ), register it as owner and enter OWN on the next cycle.
REQ-018 In ARB with no req_valid high, the block SHALL remain in ARB; last_grant SHALL be unchanged.
REQ-019 In ARB, tx_valid, busy and every req_ready bit SHALL be 0.
REQ-020 In OWN: tx_valid = req_valid[owner]; tx_data = req_data[owner]; req_ready[owner] = tx_ready; all other req_ready bits = 0 (combinational pass-through, zero added latency).
REQ-021 Latency from req_valid rising in ARB to tx_valid SHALL be exactly 1 clock cycle.
REQ-022 The owner SHALL keep the grant across beats (message lock) until a beat with req_last[owner]=1 is transferred.
REQ-023 On transfer of a last beat, the block SHALL record last_grant=owner and return to ARB on the next cycle. Re-arbitration SHALL take one cycle, so there is one bubble between messages.
REQ-024 An idle counter SHALL clear on every transfer and on entry to OWN, and SHALL increment each OWN cycle in which req_valid[owner] is 0.
REQ-025 When the idle counter reaches IDLE_TIMEOUT-1 and req_valid[owner] is still 0, the block SHALL pulse timeout_pulse, set last_grant=owner and return to ARB.
REQ-026 A rising req_valid on the owner in the same cycle as the timeout threshold SHALL cancel the release.
REQ-027 Changes on non-owner requests during OWN SHALL have no effect until the next ARB cycle.
REQ-028 Round-robin wrap: the search SHALL wrap from NUM_REQ-1 to 0; a sole active requester SHALL be re-granted back-to-back.
REQ-029 When tx_ready stays low, the owner's beat SHALL be held with no loss or duplication.
REQ-030 grant_id SHALL be registered and SHALL equal the owner index throughout OWN.

Reset
REQ-031 While rstn=0 at a clock edge: state=ARB, last_grant=NUM_REQ-1 (requester 0 wins first), idle counter=0, grant_id=0, busy=0, timeout_pulse=0; tx_valid=0 and req_ready=0 in the following cycle.
REQ-032 Reset asserted mid-message SHALL abandon the message immediately. No partial state SHALL survive, and after release the first arbitration SHALL favour requester 0.

Verification
REQ-033 After reset, req_valid=4'b1010 -> requester 1 granted: grant_id=1, tx_valid high 1 cycle later.
REQ-034 All four requesters send continuous 1-beat messages with tx_ready=1 -> grant order 0,1,2,3,0,..., one bubble cycle between grants.
REQ-035 Requester 2 sends a 3-byte message (0x41,0x42,0x43 with last on 0x43) while requester 0 is valid -> all three bytes are sent contiguously before requester 0 is granted.
REQ-036 Owner drops req_valid mid-message with IDLE_TIMEOUT=8 -> timeout_pulse fires 8 cycles later, busy=0, next valid requester granted.
REQ-037 tx_ready held low for 20 cycles during a beat -> tx_data stable, req_ready[owner]=0, then exactly one transfer when tx_ready rises.
REQ-038 rstn pulsed low during the second byte of a message -> busy=0 and tx_valid=0 after the edge; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter with message lock that shares one UART transmitter among NUM_REQ byte streams.
// Grant is registered, so the first beat follows req_valid by one cycle; beats then pass through combinationally under tx_ready.
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_pulse
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  typedef enum logic {ARB, OWN} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   idle_cnt;

  logic            own_vld;
  logic            own_last;
  logic            xfer;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

  // Owner mux: the owner's beat is forwarded with no register stage.
  always_comb begin
    own_vld   = 1'b0;
    own_last  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        own_vld  = req_valid[i];
        own_last = req_last[i];
        tx_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      req_ready[i] = (state == OWN) && (owner == IW'(i)) && tx_ready;
    end
    tx_valid = (state == OWN) && own_vld;
    xfer     = tx_valid && tx_ready;
  end

  // First valid requester searching upward from last_grant+1, wrapping at NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!pick_vld && req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= ARB;
      owner         <= '0;
      last_grant    <= LAST_IDX;
      idle_cnt      <= '0;
      grant_id      <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ARB: begin
          if (pick_vld) begin
            state    <= OWN;
            owner    <= pick_idx;
            grant_id <= pick_idx;
            busy     <= 1'b1;
            idle_cnt <= '0;
          end
        end
        OWN: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (own_last) begin
              state      <= ARB;
              last_grant <= owner;
              grant_id   <= '0;
              busy       <= 1'b0;
            end
          end else if (!own_vld) begin
            // An owner that stalls mid-message is evicted so others are not starved.
            if (idle_cnt == IDLE_LIM) begin
              state         <= ARB;
              last_grant    <= owner;
              grant_id      <= '0;
              busy          <= 1'b0;
              timeout_pulse <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
